// File: rtl/bus_dma_pkg.sv
// Shared definitions for the word-copy DMA engine: FSM encoding, word stride, pointer pair.
// No logic here. The engine imports this package and uses its names directly.
package bus_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
  } ptr_t;

  // Byte address forced onto a word boundary (low two bits dropped).
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(WORD_STRIDE - 32'd1);
  endfunction

endpackage

// File: rtl/bus_dma.sv
// Word-by-word memory copy engine; irq is sticky only when BUS_DMA_IRQ_EN is defined.
// Latency: each word takes one READ cycle and one WRITE cycle; done comes 2N+1 cycles after start.
// No backpressure: the bus responder must answer reads in the same cycle and commit writes at the edge.
module bus_dma
  import bus_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic [31:0]      Addr,
  output logic [31:0]      WriteData,
  output logic             MemRd,
  output logic             MemWr,
  input  logic [31:0]      ReadData,
  output logic             busy,
  output logic             done,
  output logic             irq,
  input  logic             irq_clr
);

  state_t           state, state_nxt;
  ptr_t             ptr;
  logic [LEN_W-1:0] cnt;
  logic [31:0]      data_q;

  logic             ld_xfer;
  logic             rd_cap;
  logic             wr_adv;

  always_comb begin
    state_nxt = state;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    Addr      = '0;
    WriteData = '0;
    busy      = 1'b0;
    done      = 1'b0;
    ld_xfer   = 1'b0;
    rd_cap    = 1'b0;
    wr_adv    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            ld_xfer   = 1'b1;
            state_nxt = ST_READ;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_READ: begin
        busy = 1'b1;
        // Abort kills the strobe in the same cycle so the bus never sees a partial access.
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          MemRd     = 1'b1;
          Addr      = ptr.src;
          rd_cap    = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          MemWr     = 1'b1;
          Addr      = ptr.dst;
          WriteData = data_q;
          wr_adv    = 1'b1;
          state_nxt = (cnt == LEN_W'(1)) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (ld_xfer) begin
        ptr.src <= word_align(src_addr);
        ptr.dst <= word_align(dst_addr);
        cnt     <= len;
      end
      if (rd_cap) begin
        data_q <= ReadData;
      end
      // Pointers wrap modulo 2^32 naturally through the 32-bit add.
      if (wr_adv) begin
        ptr.src <= ptr.src + WORD_STRIDE;
        ptr.dst <= ptr.dst + WORD_STRIDE;
        cnt     <= cnt - LEN_W'(1);
      end
    end
  end

`ifdef BUS_DMA_IRQ_EN
  logic irq_q;

  // Set has priority over clear so a completion is never lost to a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (state == ST_DONE) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = irq_clr;
  assign irq            = 1'b0;
`endif

endmodule

// File: doc/bus_dma.md
BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 Parameter LEN_W, default 16: width of the word-count input; maximum transfer 2^LEN_W-1 words.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 src_addr  input  32  source byte address; bits [1:0] ignored (treated as 0).
REQ-006 dst_addr  input  32  destination byte address; bits [1:0] ignored.
REQ-007 len  input  LEN_W  number of 32-bit words to copy.
REQ-008 abort  input  1  terminates an active transfer.
REQ-009 Addr  output  32  memory-bus address.
REQ-010 WriteData  output  32  memory-bus write data.
REQ-011 MemRd  output  1  memory-bus read strobe; ReadData valid combinationally in the same cycle.
REQ-012 MemWr  output  1  memory-bus write strobe; the responder commits on the rising edge.
REQ-013 ReadData  input  32  memory-bus read data.
REQ-014 busy  output  1  high while in READ or WRITE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 irq  output  1  sticky completion interrupt (see Configuration).
REQ-017 irq_clr  input  1  clears irq.

Function
REQ-018 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-019 IDLE: start=1 with len!=0 SHALL latch src/dst (bits [1:0] zeroed) and len, then go to READ; start=1 with len=0 SHALL go straight to DONE.
REQ-020 READ SHALL drive MemRd=1, MemWr=0, Addr=src pointer, capture ReadData into a data register at the edge, then go to WRITE.
REQ-021 WRITE SHALL drive MemWr=1, MemRd=0, Addr=dst pointer, WriteData=data register; at the edge, both pointers increase by 4 (mod 2^32 wrap) and remaining count decreases by 1.
REQ-022 After WRITE, remaining count !=0 SHALL go to READ; ==0 SHALL go to DONE.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-024 Latency: N words SHALL produce done exactly 2N+1 cycles after the edge sampling start (len=0: 1 cycle).
REQ-025 MemRd and MemWr SHALL never be high in the same cycle; in IDLE and DONE both SHALL be 0, Addr and WriteData 0.
REQ-026 start while not in IDLE SHALL be ignored; new inputs SHALL NOT disturb a transfer in progress.
REQ-027 abort in READ or WRITE SHALL suppress that cycle's strobe, return to IDLE at the next edge, and produce no done and no irq; abort in IDLE/DONE SHALL be ignored.
REQ-028 Source/destination overlap SHALL NOT be detected; words are copied in ascending address order.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE and clear pointers, count, data register, done, irq; it SHALL override start, abort and an in-flight transfer (no further strobes).
REQ-030 After reset: busy=0, done=0, irq=0, MemRd=0, MemWr=0, Addr=0, WriteData=0.

Configuration
REQ-031 With macro BUS_DMA_IRQ_EN defined, irq SHALL set on the edge leaving DONE and stay high until irq_clr=1 is sampled; a simultaneous set and clear SHALL leave irq=1.
REQ-032 Without BUS_DMA_IRQ_EN, irq SHALL be constant 0, irq_clr SHALL be ignored, and no irq register SHALL exist.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (2 bits) and the word-stride constant (4).
REQ-034 No sub-module is required; the FSM and datapath live in bus_dma.

Verification
REQ-035 Copy: src=0x00000000, dst=0x00000040, len=3, memory pre-loaded 0x75680150/0x11111111/0x22222222 -> words 0x40..0x48 match, done at cycle 7, busy high cycles 1..6.
REQ-036 len=0, start=1 -> no MemRd/MemWr strobe, done pulse on the next cycle, irq=1 with macro.
REQ-037 Unaligned: src=0x00000003, dst=0x00000011, len=1 -> reads 0x00000000, writes 0x00000010.
REQ-038 Wrap: src=0xFFFFFFFC, len=2 -> second read at Addr=0x00000000.
REQ-039 abort in the second WRITE of len=4 -> exactly one write committed, no done, IDLE next cycle; a new start then runs normally.
REQ-040 reset mid-transfer plus a start pulse during busy -> outputs all 0 after reset, the ignored start causes no extra transfer, MemRd&MemWr never both 1.
